multicycle_control_unit: RTL and testbench

Multi-cycle successor to the single-cycle opcode decoder. It sequences every instruction through FETCH/DECODE/EXEC/MEM/WB states and issues strobes one state at a time. Instruction memory, data memory and the I/O port are ready/valid handshakes, so the unit can stall on slow memories and external I/O. It sits between the instruction register and the shared datapath: register file, ALU, PC and memory ports.

---
 rtl/multicycle_control_unit_if.sv | 45 ++++
 rtl/multicycle_control_unit.sv | 183 ++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_unit_if.sv
// Control-unit bundle: IR opcode, memory/IO handshakes and all datapath strobes.
// master is the control unit; slave is the datapath/environment side.
interface multicycle_control_unit_if #(
   parameter int OPCODE_W = 6,
   parameter int ALUOP_W  = 3
);
   logic [OPCODE_W-1:0] opcode;
   logic                imem_ready;
   logic                dmem_ready;
   logic                input_valid;
   logic                output_ack;
   logic                resume;

   logic                ir_write;
   logic                instr_fetch;
   logic                pc_write;
   logic [1:0]          RegisterDST;
   logic [1:0]          Jump;
   logic [1:0]          memtoReg;
   logic                Branch;
   logic                ALUSrc;
   logic                regWrite;
   logic                memWrite;
   logic                memRead;
   logic [ALUOP_W-1:0]  Alu_op;
   logic                halt;
   logic                output_flag;
   logic                input_flag;
   logic                illegal;
   logic [2:0]          state;

   modport master (
      input  opcode, imem_ready, dmem_ready, input_valid, output_ack, resume,
      output ir_write, instr_fetch, pc_write, RegisterDST, Jump, memtoReg,
             Branch, ALUSrc, regWrite, memWrite, memRead, Alu_op,
             halt, output_flag, input_flag, illegal, state
   );

   modport slave (
      output opcode, imem_ready, dmem_ready, input_valid, output_ack, resume,
      input  ir_write, instr_fetch, pc_write, RegisterDST, Jump, memtoReg,
             Branch, ALUSrc, regWrite, memWrite, memRead, Alu_op,
             halt, output_flag, input_flag, illegal, state
   );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle instruction sequencer driving the shared datapath one state at a time.
//
// state    | meaning
// FETCH    | read IMEM into IR, bump PC when imem_ready
// DECODE   | capture opcode, dispatch
// EXEC     | ALU op, branch/jump resolution
// MEM      | data memory access, wait for dmem_ready
// WB       | register file write
// IN_WAIT  | wait for input_valid, write input word
// OUT_WAIT | wait for output_ack
// HALTED   | sticky halt until resume
module multicycle_control_unit #(
   parameter int OPCODE_W = 6,
   parameter int ALUOP_W  = 3
) (
   input logic                      clock,
   input logic                      reset,
   multicycle_control_unit_if.master bus
);

   typedef enum logic [2:0] {
      FETCH    = 3'd0,
      DECODE   = 3'd1,
      EXEC     = 3'd2,
      MEM      = 3'd3,
      WB       = 3'd4,
      IN_WAIT  = 3'd5,
      OUT_WAIT = 3'd6,
      HALTED   = 3'd7
   } state_t;

   localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(0);
   localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(1);
   localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(2);
   localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(3);
   localparam logic [OPCODE_W-1:0] OP_SUBI = OPCODE_W'(4);
   localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(5);
   localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(9);
   localparam logic [OPCODE_W-1:0] OP_JR   = OPCODE_W'(10);
   localparam logic [OPCODE_W-1:0] OP_JAL  = OPCODE_W'(11);
   localparam logic [OPCODE_W-1:0] OP_IN   = OPCODE_W'(12);
   localparam logic [OPCODE_W-1:0] OP_OUT  = OPCODE_W'(13);
   localparam logic [OPCODE_W-1:0] OP_HALT = '1;

   state_t              state;
   logic [OPCODE_W-1:0] op_q;
   logic [OPCODE_W-1:0] sel_op;

   function automatic logic op_legal(input logic [OPCODE_W-1:0] op);
      case (op)
         OP_R, OP_LW, OP_SW, OP_ADDI, OP_SUBI, OP_BEQ,
         OP_J, OP_JR, OP_JAL, OP_IN, OP_OUT, OP_HALT: return 1'b1;
         default:                                     return 1'b0;
      endcase
   endfunction

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= FETCH;
         op_q  <= '0;
      end else begin
         case (state)
            FETCH:    if (bus.imem_ready) state <= DECODE;
            DECODE: begin
               op_q <= bus.opcode;
               case (bus.opcode)
                  OP_HALT: state <= HALTED;
                  OP_IN:   state <= IN_WAIT;
                  OP_OUT:  state <= OUT_WAIT;
                  default: state <= op_legal(bus.opcode) ? EXEC : FETCH;
               endcase
            end
            EXEC: begin
               case (op_q)
                  OP_R, OP_ADDI, OP_SUBI: state <= WB;
                  OP_LW, OP_SW:           state <= MEM;
                  default:                state <= FETCH;
               endcase
            end
            MEM:      if (bus.dmem_ready) state <= (op_q == OP_LW) ? WB : FETCH;
            WB:       state <= FETCH;
            IN_WAIT:  if (bus.input_valid) state <= FETCH;
            OUT_WAIT: if (bus.output_ack) state <= FETCH;
            HALTED:   if (bus.resume) state <= FETCH;
            default:  state <= FETCH;
         endcase
      end
   end

   // DECODE shows the live opcode; later states hold the captured copy.
   assign sel_op    = (state == DECODE) ? bus.opcode : op_q;
   assign bus.state = state;

   // Gated by reset so that nothing is asserted while reset is held low.
   always_comb begin
      bus.ir_write    = 1'b0;
      bus.instr_fetch = 1'b0;
      bus.pc_write    = 1'b0;
      bus.RegisterDST = 2'd0;
      bus.Jump        = 2'd0;
      bus.memtoReg    = 2'd0;
      bus.Branch      = 1'b0;
      bus.ALUSrc      = 1'b0;
      bus.regWrite    = 1'b0;
      bus.memWrite    = 1'b0;
      bus.memRead     = 1'b0;
      bus.Alu_op      = '0;
      bus.halt        = 1'b0;
      bus.output_flag = 1'b0;
      bus.input_flag  = 1'b0;
      bus.illegal     = 1'b0;
      if (reset) begin
         if (state != FETCH && state != HALTED) begin
            case (sel_op)
               OP_R: begin
                  bus.RegisterDST = 2'd1;
                  bus.Alu_op      = ALUOP_W'(4);
               end
               OP_LW: begin
                  bus.memtoReg = 2'd1;
                  bus.ALUSrc   = 1'b1;
               end
               OP_SW, OP_ADDI: bus.ALUSrc = 1'b1;
               OP_SUBI: begin
                  bus.ALUSrc = 1'b1;
                  bus.Alu_op = ALUOP_W'(1);
               end
               OP_BEQ: bus.Alu_op = ALUOP_W'(3);
               OP_JR:  bus.RegisterDST = 2'd2;
               OP_JAL: begin
                  bus.RegisterDST = 2'd2;
                  bus.memtoReg    = 2'd2;
               end
               OP_IN: begin
                  bus.RegisterDST = 2'd3;
                  bus.memtoReg    = 2'd3;
               end
               default: ;
            endcase
         end
         case (state)
            FETCH: begin
               bus.ir_write    = 1'b1;
               bus.instr_fetch = 1'b1;
               bus.pc_write    = bus.imem_ready;
            end
            DECODE: bus.illegal = !op_legal(bus.opcode);
            EXEC: begin
               case (op_q)
                  OP_BEQ: bus.Branch = 1'b1;
                  OP_J: begin
                     bus.Jump     = 2'd1;
                     bus.pc_write = 1'b1;
                  end
                  OP_JR: begin
                     bus.Jump     = 2'd2;
                     bus.pc_write = 1'b1;
                  end
                  OP_JAL: begin
                     bus.Jump     = 2'd1;
                     bus.pc_write = 1'b1;
                     bus.regWrite = 1'b1;
                  end
                  default: ;
               endcase
            end
            MEM: begin
               bus.memRead  = (op_q == OP_LW);
               bus.memWrite = (op_q == OP_SW);
            end
            WB: bus.regWrite = 1'b1;
            IN_WAIT: begin
               bus.input_flag = 1'b1;
               bus.regWrite   = bus.input_valid;
            end
            OUT_WAIT: bus.output_flag = 1'b1;
            HALTED:   bus.halt = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: instruction-level trace model versus DUT, cycle by cycle.
module tb_multicycle_control_unit;

   typedef struct packed {
      logic       ir_write;
      logic       instr_fetch;
      logic       pc_write;
      logic [1:0] rdst;
      logic [1:0] jump;
      logic [1:0] m2r;
      logic       branch;
      logic       alusrc;
      logic       regwrite;
      logic       memwrite;
      logic       memread;
      logic [2:0] aluop;
      logic       halt;
      logic       oflag;
      logic       iflag;
      logic       illegal;
      logic [2:0] state;
   } outs_t;

   typedef struct {
      logic [5:0] opc;
      logic       im, dm, iv, oa, rs;
      outs_t      exp;
   } cyc_t;

   logic clock;
   logic reset;
   int   checks;
   int   failures;
   cyc_t q[$];

   multicycle_control_unit_if #(.OPCODE_W(6), .ALUOP_W(3)) bus ();

   multicycle_control_unit #(.OPCODE_W(6), .ALUOP_W(3)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic outs_t sample();
      outs_t a;
      a.ir_write    = bus.ir_write;
      a.instr_fetch = bus.instr_fetch;
      a.pc_write    = bus.pc_write;
      a.rdst        = bus.RegisterDST;
      a.jump        = bus.Jump;
      a.m2r         = bus.memtoReg;
      a.branch      = bus.Branch;
      a.alusrc      = bus.ALUSrc;
      a.regwrite    = bus.regWrite;
      a.memwrite    = bus.memWrite;
      a.memread     = bus.memRead;
      a.aluop       = bus.Alu_op;
      a.halt        = bus.halt;
      a.oflag       = bus.output_flag;
      a.iflag       = bus.input_flag;
      a.illegal     = bus.illegal;
      a.state       = bus.state;
      return a;
   endfunction

   function automatic logic is_legal(input logic [5:0] op);
      return op inside {6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd9, 6'd10, 6'd11, 6'd12, 6'd13, 6'd63};
   endfunction

   // Instruction select table, applied on top of a per-cycle record.
   function automatic outs_t with_sels(input outs_t e, input logic [5:0] op);
      outs_t r = e;
      case (op)
         6'd0:  begin r.rdst = 2'd1; r.aluop = 3'd4; end
         6'd1:  begin r.m2r = 2'd1; r.alusrc = 1'b1; end
         6'd2:  r.alusrc = 1'b1;
         6'd3:  r.alusrc = 1'b1;
         6'd4:  begin r.alusrc = 1'b1; r.aluop = 3'd1; end
         6'd5:  r.aluop = 3'd3;
         6'd10: r.rdst = 2'd2;
         6'd11: begin r.rdst = 2'd2; r.m2r = 2'd2; end
         6'd12: begin r.rdst = 2'd3; r.m2r = 2'd3; end
         default: ;
      endcase
      return r;
   endfunction

   // Record with every input randomised; the caller pins the one that matters.
   function automatic cyc_t mk(input logic [5:0] opc, input logic [2:0] st);
      cyc_t c;
      c.opc       = opc;
      c.im        = 1'($urandom);
      c.dm        = 1'($urandom);
      c.iv        = 1'($urandom);
      c.oa        = 1'($urandom);
      c.rs        = 1'($urandom);
      c.exp       = '0;
      c.exp.state = st;
      return c;
   endfunction

   // Expected cycle trace of one instruction: fw fetch stalls, mw memory stalls,
   // iw cycles waiting on the I/O handshake (or held in HALTED before resume).
   task automatic gen(input logic [5:0] op, input int fw, input int mw, input int iw);
      cyc_t c;
      for (int i = 0; i < fw; i++) begin
         c = mk(6'($urandom), 3'd0);
         c.im = 1'b0;
         c.exp.ir_write = 1'b1; c.exp.instr_fetch = 1'b1;
         q.push_back(c);
      end
      c = mk(6'($urandom), 3'd0);
      c.im = 1'b1;
      c.exp.ir_write = 1'b1; c.exp.instr_fetch = 1'b1; c.exp.pc_write = 1'b1;
      q.push_back(c);

      c = mk(op, 3'd1);
      c.exp = with_sels(c.exp, op);
      c.exp.illegal = !is_legal(op);
      q.push_back(c);
      if (!is_legal(op)) return;

      if (op == 6'd63) begin
         for (int i = 0; i < iw; i++) begin
            c = mk(op, 3'd7); c.rs = 1'b0; c.exp.halt = 1'b1; q.push_back(c);
         end
         c = mk(op, 3'd7); c.rs = 1'b1; c.exp.halt = 1'b1; q.push_back(c);
         return;
      end
      if (op == 6'd12 || op == 6'd13) begin
         for (int i = 0; i <= iw; i++) begin
            c = mk(op, (op == 6'd12) ? 3'd5 : 3'd6);
            c.exp = with_sels(c.exp, op);
            if (op == 6'd12) begin
               c.iv = (i == iw);
               c.exp.iflag = 1'b1;
               c.exp.regwrite = (i == iw);
            end else begin
               c.oa = (i == iw);
               c.exp.oflag = 1'b1;
            end
            q.push_back(c);
         end
         return;
      end

      c = mk(op, 3'd2);
      c.exp = with_sels(c.exp, op);
      c.exp.branch   = (op == 6'd5);
      c.exp.jump     = (op == 6'd9 || op == 6'd11) ? 2'd1 : (op == 6'd10) ? 2'd2 : 2'd0;
      c.exp.pc_write = op inside {6'd9, 6'd10, 6'd11};
      c.exp.regwrite = (op == 6'd11);
      q.push_back(c);
      if (op inside {6'd5, 6'd9, 6'd10, 6'd11}) return;

      if (op == 6'd1 || op == 6'd2) begin
         for (int i = 0; i <= mw; i++) begin
            c = mk(op, 3'd3);
            c.dm = (i == mw);
            c.exp = with_sels(c.exp, op);
            c.exp.memread  = (op == 6'd1);
            c.exp.memwrite = (op == 6'd2);
            q.push_back(c);
         end
         if (op == 6'd2) return;
      end

      c = mk(op, 3'd4);
      c.exp = with_sels(c.exp, op);
      c.exp.regwrite = 1'b1;
      q.push_back(c);
   endtask

   // Plays up to max queued records (max < 0: all), checking each cycle.
   task automatic run(input string name, input int max);
      cyc_t  c;
      outs_t a;
      int    n = 0;
      while (q.size() > 0 && (max < 0 || n < max)) begin
         c = q.pop_front();
         @(negedge clock);
         bus.opcode      = c.opc;
         bus.imem_ready  = c.im;
         bus.dmem_ready  = c.dm;
         bus.input_valid = c.iv;
         bus.output_ack  = c.oa;
         bus.resume      = c.rs;
         #1;
         a = sample();
         checks++;
         if (a !== c.exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", name, n, a, c.exp);
         end
         checks++;
         if (a.regwrite && a.memwrite) begin
            failures++;
            $display("FAIL %s_rw_mw cycle=%0d actual=11 expected=not both", name, n);
         end
         n++;
      end
   endtask

   task automatic idle_inputs();
      bus.opcode      = 6'd0;
      bus.imem_ready  = 1'b0;
      bus.dmem_ready  = 1'b0;
      bus.input_valid = 1'b0;
      bus.output_ack  = 1'b0;
      bus.resume      = 1'b0;
   endtask

   task automatic test_reset();
      outs_t a;
      idle_inputs();
      bus.imem_ready = 1'b1;
      reset = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      #1;
      a = sample();
      checks++;
      if (a !== outs_t'(0)) begin
         failures++;
         $display("FAIL reset_outputs actual=%h expected=%h", a, outs_t'(0));
      end
      bus.imem_ready = 1'b0;
      reset = 1'b1;
   endtask

   task automatic test_reset_mid_mem();
      outs_t a, e;
      gen(6'd1, 0, 5, 0);
      run("rst_mid_lw", 4);
      q.delete();
      bus.dmem_ready = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      a = sample();
      checks++;
      if (a !== outs_t'(0)) begin
         failures++;
         $display("FAIL reset_mid_mem actual=%h expected=%h", a, outs_t'(0));
      end
      @(negedge clock);
      bus.imem_ready = 1'b0;
      reset = 1'b1;
      #1;
      a = sample();
      e = '0;
      e.ir_write = 1'b1;
      e.instr_fetch = 1'b1;
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL reset_release_fetch actual=%h expected=%h", a, e);
      end
   endtask

   task automatic test_addi();
      gen(6'd3, 0, 0, 0);
      run("addi", -1);
   endtask

   task automatic test_lw_stall();
      gen(6'd1, 0, 2, 0);
      run("lw_stall", -1);
   endtask

   task automatic test_in_wait();
      gen(6'd12, 0, 0, 3);
      run("in_wait", -1);
   endtask

   task automatic test_halt();
      gen(6'd63, 0, 0, 10);
      gen(6'd9, 0, 0, 0);
      run("halt_resume", -1);
   endtask

   task automatic test_illegal_jal();
      gen(6'd7, 0, 0, 0);
      gen(6'd11, 0, 0, 0);
      gen(6'd13, 1, 0, 2);
      run("illegal_jal_out", -1);
   endtask

   task automatic test_back_to_back();
      logic [5:0] legal_ops [12];
      logic [5:0] op;
      legal_ops = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd9, 6'd10, 6'd11, 6'd12, 6'd13, 6'd63};
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 3) != 0) op = legal_ops[$urandom_range(0, 11)];
         else                           op = 6'($urandom_range(0, 63));
         gen(op, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      end
      run("random", -1);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_addi();
      test_reset_mid_mem();
      test_lw_stall();
      test_in_wait();
      test_halt();
      test_illegal_jal();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
